column_height: RTL and testbench

// - Downstream of the ray tracer. Takes each per-column hit result (column, side, vdist UQ7.9, tex) from the tracer's 1-cycle store pulse.
// - Computes the on-screen wall height = SCALE_NUM / vdist with an iterative divider, saturated to HEIGHT_MAX.
// - Writes {height, side, tex} to the trace_buffer write port, which the VGA renderer reads during the visible frame.

---
 rtl/column_height_pkg.sv | 21 ++
 rtl/column_height_fifo.sv | 64 ++++++
 rtl/column_height.sv | 233 +++++++++++++++++++++++
 tb/tb_column_height.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/column_height_pkg.sv
// Shared widths and types for column_height: UQ7.9 distance, height/tex/column widths,
// queue entry layout and FSM states.
package column_height_pkg;
    localparam int VDIST_W  = 16;
    localparam int HEIGHT_W = 10;
    localparam int TEX_W    = 6;
    localparam int COL_W    = 10;
    localparam int ADDR_W   = 9;
    // Holds a partial remainder below vdist shifted left once, so 17 bits always suffice.
    localparam int REM_W    = 18;
    localparam int SAT_W    = VDIST_W + HEIGHT_W;

    typedef enum logic [1:0] { S_IDLE, S_LOAD, S_DIV, S_WRITE } state_e;

    typedef struct packed {
        logic [COL_W-1:0]   column;
        logic               side;
        logic [VDIST_W-1:0] vdist;
        logic [TEX_W-1:0]   tex;
    } entry_t;
endpackage

// File: rtl/column_height_fifo.sv
// Generic synchronous FIFO with sync clear; a push into a full FIFO is dropped unless a
// pop happens in the same cycle.
module column_height_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign dout    = mem_q[rp_q];
    assign count   = count_q;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (clear) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wp_d = wp_q + AW'(1);
            if (do_pop)  rp_d = rp_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din;
    end
endmodule

// File: rtl/column_height.sv
// Wall height = SCALE_NUM / vdist per tracer column, queued and written to the trace buffer.
// Optional COLUMN_HEIGHT_STATS_EN adds write-count and peak-queue-fill statistics ports.
module column_height
    import column_height_pkg::*;
#(
    parameter int SCALE_NUM  = 131072,
    parameter int HEIGHT_MAX = 1023,
    parameter int RADIX_BITS = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int COL_BASE   = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_store,
    input  logic [COL_W-1:0]    in_column,
    input  logic                in_side,
    input  logic [VDIST_W-1:0]  in_vdist,
    input  logic [TEX_W-1:0]    in_tex,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [HEIGHT_W-1:0] wr_height,
    output logic                wr_side,
    output logic [TEX_W-1:0]    wr_tex,
    output logic                busy,
    output logic                overflow
`ifdef COLUMN_HEIGHT_STATS_EN
    ,
    output logic [9:0]                    stat_writes,
    output logic [$clog2(FIFO_DEPTH):0]   stat_maxfill
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_CYC = HEIGHT_W / RADIX_BITS;
    localparam logic [3:0]          DIV_LAST   = 4'(DIV_CYC - 1);
    localparam logic [SAT_W-1:0]    SCALE_C    = SAT_W'(SCALE_NUM);
    localparam logic [REM_W-1:0]    REM_INIT   = REM_W'(SCALE_NUM >> HEIGHT_W);
    localparam logic [HEIGHT_W-1:0] DVD_INIT   = HEIGHT_W'(SCALE_NUM % (1 << HEIGHT_W));
    localparam logic [HEIGHT_W-1:0] HMAX_C     = HEIGHT_W'(HEIGHT_MAX);
    localparam logic [COL_W-1:0]    COL_BASE_C = COL_W'(COL_BASE);

    entry_t        fifo_in, fifo_out;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    state_e                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  side_q, side_d;
    logic [VDIST_W-1:0]    vdist_q, vdist_d;
    logic [TEX_W-1:0]      tex_q, tex_d;
    logic                  sat_q, sat_d;
    logic [REM_W-1:0]      rem_q, rem_d, div_rem;
    logic [HEIGHT_W-1:0]   dvd_q, dvd_d, div_dvd;
    logic [HEIGHT_W-1:0]   quo_q, quo_d, div_quo;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [HEIGHT_W-1:0]   wr_height_q, wr_height_d;
    logic                  wr_side_q, wr_side_d;
    logic [TEX_W-1:0]      wr_tex_q, wr_tex_d;
    logic                  overflow_q, overflow_d;

    assign fifo_in   = {in_column, in_side, in_vdist, in_tex};
    assign fifo_push = in_store && !flush;

    column_height_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_in),
        .dout    (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // RADIX_BITS restoring steps; the dividend's top bits are pre-loaded into the remainder.
    always_comb begin
        div_rem = rem_q;
        div_dvd = dvd_q;
        div_quo = quo_q;
        for (int i = 0; i < RADIX_BITS; i++) begin
            div_rem = {div_rem[REM_W-2:0], div_dvd[HEIGHT_W-1]};
            div_dvd = {div_dvd[HEIGHT_W-2:0], 1'b0};
            if (div_rem >= REM_W'(vdist_q)) begin
                div_rem = div_rem - REM_W'(vdist_q);
                div_quo = {div_quo[HEIGHT_W-2:0], 1'b1};
            end else begin
                div_quo = {div_quo[HEIGHT_W-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        side_d      = side_q;
        vdist_d     = vdist_q;
        tex_d       = tex_q;
        sat_d       = sat_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_height_d = wr_height_q;
        wr_side_d   = wr_side_q;
        wr_tex_d    = wr_tex_q;
        overflow_d  = overflow_q | (fifo_push && fifo_full && !fifo_pop);
        fifo_pop    = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            {col_d, side_d, vdist_d, tex_d, sat_d} = '0;
            {rem_d, dvd_d, quo_d, cnt_d} = '0;
            {wr_addr_d, wr_height_d, wr_side_d, wr_tex_d} = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        col_d    = fifo_out.column;
                        side_d   = fifo_out.side;
                        vdist_d  = fifo_out.vdist;
                        tex_d    = fifo_out.tex;
                        state_d  = S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Quotient >= 2^HEIGHT_W (vdist=0 included) bypasses the divider.
                    sat_d   = (SCALE_C >= {vdist_q, {HEIGHT_W{1'b0}}});
                    rem_d   = REM_INIT;
                    dvd_d   = DVD_INIT;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = sat_d ? S_WRITE : S_DIV;
                end
                S_DIV: begin
                    rem_d = div_rem;
                    dvd_d = div_dvd;
                    quo_d = div_quo;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == DIV_LAST) state_d = S_WRITE;
                end
                S_WRITE: begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = ADDR_W'(col_q - COL_BASE_C);
                    wr_height_d = (sat_q || quo_q > HMAX_C) ? HMAX_C : quo_q;
                    wr_side_d   = side_q;
                    wr_tex_d    = tex_q;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            side_q      <= 1'b0;
            vdist_q     <= '0;
            tex_q       <= '0;
            sat_q       <= 1'b0;
            rem_q       <= '0;
            dvd_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_height_q <= '0;
            wr_side_q   <= 1'b0;
            wr_tex_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            side_q      <= side_d;
            vdist_q     <= vdist_d;
            tex_q       <= tex_d;
            sat_q       <= sat_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_height_q <= wr_height_d;
            wr_side_q   <= wr_side_d;
            wr_tex_q    <= wr_tex_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_height = wr_height_q;
    assign wr_side   = wr_side_q;
    assign wr_tex    = wr_tex_q;
    assign overflow  = overflow_q;
    assign busy      = (fifo_count != '0) || (state_q != S_IDLE);

`ifdef COLUMN_HEIGHT_STATS_EN
    logic [9:0]    stat_writes_q, stat_writes_d;
    logic [CW-1:0] stat_maxfill_q, stat_maxfill_d;

    always_comb begin
        stat_writes_d  = stat_writes_q + 10'(wr_en_q);
        stat_maxfill_d = (fifo_count > stat_maxfill_q) ? fifo_count : stat_maxfill_q;
        if (flush) begin
            stat_writes_d  = '0;
            stat_maxfill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_writes_q  <= '0;
            stat_maxfill_q <= '0;
        end else begin
            stat_writes_q  <= stat_writes_d;
            stat_maxfill_q <= stat_maxfill_d;
        end
    end

    assign stat_writes  = stat_writes_q;
    assign stat_maxfill = stat_maxfill_q;
`endif
endmodule

// File: tb/tb_column_height.sv
// Bench for column_height: directed scenarios plus randomized traffic against a
// queue/latency reference model of the block's behaviour.
module tb_column_height;
    localparam int DEPTH = 4;
    localparam int SCALE = 131072;

    typedef struct packed {
        logic [31:0] cyc;
        logic [8:0]  addr;
        logic [9:0]  height;
        logic        side;
        logic [5:0]  tex;
    } wr_t;
    typedef struct packed {
        logic [9:0]  col;
        logic        side;
        logic [15:0] vd;
        logic [5:0]  tex;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_store = 1'b0;
    logic [9:0]  in_column = '0;
    logic        in_side = 1'b0;
    logic [15:0] in_vdist = '0;
    logic [5:0]  in_tex = '0;
    logic        wr_en, wr_side, busy, overflow;
    logic [8:0]  wr_addr;
    logic [9:0]  wr_height;
    logic [5:0]  wr_tex;

    column_height dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_store(in_store),
        .in_column(in_column), .in_side(in_side), .in_vdist(in_vdist), .in_tex(in_tex),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_height(wr_height), .wr_side(wr_side),
        .wr_tex(wr_tex), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   next_pop = 0;
    bit   ov = 0;
    ent_t mq[$];
    wr_t  exp_q[$];
    wr_t  obs[$];

    // One clock: drive at negedge, advance the model at posedge, record writes at negedge.
    task automatic step(input logic st, input logic [9:0] col, input logic sd,
                        input logic [15:0] vd, input logic [5:0] tx, input logic fl);
        ent_t e;
        wr_t  w;
        bit   sat;
        int   h;
        in_store = st; in_column = col; in_side = sd; in_vdist = vd; in_tex = tx; flush = fl;
        @(posedge clk);
        cyc++;
        if (fl) begin
            mq.delete();
            ov = 0;
            next_pop = 0;
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (int'(exp_q[i].cyc) >= cyc) exp_q.delete(i);
        end else begin
            if (cyc >= next_pop && mq.size() > 0) begin
                e   = mq.pop_front();
                sat = (int'(e.vd) * 1024 <= SCALE);
                h   = sat ? 1023 : SCALE / int'(e.vd);
                if (h > 1023) h = 1023;
                w.cyc    = 32'(cyc + (sat ? 2 : 7));
                w.addr   = 9'(int'(e.col) - 64);
                w.height = 10'(h);
                w.side   = e.side;
                w.tex    = e.tex;
                exp_q.push_back(w);
                next_pop = int'(w.cyc) + 1;
            end
            if (st) begin
                if (mq.size() < DEPTH) mq.push_back(ent_t'({col, sd, vd, tx}));
                else ov = 1;
            end
        end
        @(negedge clk);
        if (wr_en) obs.push_back(wr_t'({32'(cyc), wr_addr, wr_height, wr_side, wr_tex}));
        in_store = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 10'd0, 1'b0, 16'd0, 6'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; flush = 1'b0; in_store = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        ov = 0;
        next_pop = 0;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (int'(exp_q[i].cyc) > cyc) exp_q.delete(i);
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_height, wr_side, wr_tex} !== '0) begin
            errors++; $display("FAIL reset_wr: got %h required 0", {wr_en, wr_addr, wr_height, wr_side, wr_tex});
        end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy=%b overflow=%b required 0 0", busy, overflow);
        end
        do_reset();
        idle(4);
        checks++;
        if (obs.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_quiet: writes=%0d busy=%b required 0 0", obs.size(), busy);
        end
    endtask

    task automatic test_single();
        int p;
        do_reset();
        step(1'b1, 10'd64, 1'b1, 16'd512, 6'd5, 1'b0);
        p = cyc;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
        idle(12);
        checks++;
        if (obs.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d writes required 1", obs.size());
        end else begin
            checks++;
            if (int'(obs[0].cyc) - p != 8) begin
                errors++; $display("FAIL single_latency: got %0d required 8", int'(obs[0].cyc) - p);
            end
            checks++;
            if (obs[0].addr !== 9'd0 || obs[0].height !== 10'd256 || obs[0].side !== 1'b1 || obs[0].tex !== 6'd5) begin
                errors++; $display("FAIL single_fields: got addr=%0d h=%0d side=%b tex=%0d required 0 256 1 5",
                                   obs[0].addr, obs[0].height, obs[0].side, obs[0].tex);
            end
        end
        checks++;
        if (wr_height !== 10'd256 || busy !== 1'b0) begin
            errors++; $display("FAIL single_hold: got h=%0d busy=%b required 256 0", wr_height, busy);
        end
    endtask

    task automatic test_sat();
        logic [15:0] vds [3];
        int p;
        vds = '{16'd0, 16'd100, 16'd128};
        foreach (vds[k]) begin
            do_reset();
            step(1'b1, 10'd300, 1'b0, vds[k], 6'd17, 1'b0);
            p = cyc;
            idle(8);
            checks++;
            if (obs.size() != 1 || int'(obs[0].cyc) - p != 3 || obs[0].height !== 10'd1023 || obs[0].addr !== 9'd236) begin
                errors++; $display("FAIL sat_vd%0d: writes=%0d lat=%0d h=%0d required 1 3 1023",
                                   vds[k], obs.size(), obs.size() ? int'(obs[0].cyc) - p : -1,
                                   obs.size() ? obs[0].height : 10'd0);
            end
        end
    endtask

    task automatic test_values();
        logic [15:0] vds [4];
        logic [9:0]  hs  [4];
        int p;
        vds = '{16'd65535, 16'd1000, 16'd129, 16'd513};
        hs  = '{10'd2, 10'd131, 10'd1016, 10'd255};
        foreach (vds[k]) begin
            do_reset();
            step(1'b1, 10'd575, 1'b1, vds[k], 6'd63, 1'b0);
            p = cyc;
            idle(10);
            checks++;
            if (obs.size() != 1 || int'(obs[0].cyc) - p != 8 || obs[0].height !== hs[k] || obs[0].addr !== 9'd511) begin
                errors++; $display("FAIL div_vd%0d: writes=%0d h=%0d required 1 write h=%0d",
                                   vds[k], obs.size(), obs.size() ? obs[0].height : 10'd0, hs[k]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b1, 10'(100 + i), 1'($urandom), 16'($urandom_range(129, 65535)), 6'($urandom), 1'b0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        idle(60);
        checks++;
        if (obs.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d writes required 5", obs.size()); end
        for (int i = 0; i < obs.size(); i++) begin
            checks++;
            if (obs[i].addr !== 9'(36 + i)) begin
                errors++; $display("FAIL ovf_order[%0d]: got addr %0d required %0d", i, obs[i].addr, 36 + i);
            end
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL ovf_model_count: got %0d required %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_write[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_stream();
        int bad;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 10'(64 + i), 1'($urandom), 16'($urandom_range(0, 128)), 6'($urandom), 1'b0);
            idle(3);
        end
        idle(10);
        checks++;
        if (obs.size() != 512) begin errors++; $display("FAIL stream_count: got %0d required 512", obs.size()); end
        bad = 0;
        for (int i = 0; i < obs.size(); i++) if (obs[i].addr !== 9'(i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stream_addr_order: got %0d misplaced required 0", bad); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf: got %b required 0", overflow); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL stream_write[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] vd;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            vd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom);
            step(($urandom_range(0, 2) == 0), 10'($urandom_range(64, 575)), 1'($urandom), vd, 6'($urandom), 1'b0);
        end
        idle(60);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d required %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rand_write[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if (overflow !== ov) begin errors++; $display("FAIL rand_ovf: got %b required %b", overflow, ov); end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        step(1'b1, 10'd70, 1'b1, 16'd50, 6'd9, 1'b0);
        idle(4);
        step(1'b1, 10'd71, 1'b0, 16'd1000, 6'd3, 1'b0);
        idle(3);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || wr_height !== 10'd0 || wr_addr !== 9'd0) begin
            errors++; $display("FAIL rst_mid_clear: busy=%b wr_en=%b h=%0d addr=%0d required all 0",
                               busy, wr_en, wr_height, wr_addr);
        end
        do_reset();
        idle(12);
        checks++;
        if (obs.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet: writes=%0d busy=%b required 0 0", obs.size(), busy);
        end
    endtask

    task automatic test_flush_mid_div();
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b1, 10'(200 + i), 1'b0, 16'($urandom_range(129, 65535)), 6'(i), 1'b0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf: got %b required 1", overflow); end
        step(1'b0, 10'd0, 1'b0, 16'd0, 6'd0, 1'b1);
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0 || wr_en !== 1'b0) begin
            errors++; $display("FAIL flush_clear: busy=%b overflow=%b wr_en=%b required 0 0 0", busy, overflow, wr_en);
        end
        step(1'b1, 10'd300, 1'b1, 16'd50, 6'd1, 1'b1);
        idle(20);
        checks++;
        if (obs.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_quiet: writes=%0d busy=%b required 0 0", obs.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sat();
        test_values();
        test_overflow();
        test_stream();
        test_random();
        test_reset_mid_div();
        test_flush_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
